// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode constants, immediate-type enum,
// stored decode bundle and small classification helpers.
package decode_pkg;

    localparam logic [4:0] OP_LOAD     = 5'b00000;
    localparam logic [4:0] OP_MISC_MEM = 5'b00011;
    localparam logic [4:0] OP_IMM      = 5'b00100;
    localparam logic [4:0] OP_AUIPC    = 5'b00101;
    localparam logic [4:0] OP_STORE    = 5'b01000;
    localparam logic [4:0] OP_OP       = 5'b01100;
    localparam logic [4:0] OP_LUI      = 5'b01101;
    localparam logic [4:0] OP_BRANCH   = 5'b11000;
    localparam logic [4:0] OP_JALR     = 5'b11001;
    localparam logic [4:0] OP_JAL      = 5'b11011;
    localparam logic [4:0] OP_SYSTEM   = 5'b11100;

    typedef enum logic [2:0] {
        IMM_R,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    // Register/function fields kept per entry; imm and pc are stored
    // alongside because their widths are parameters of the queue.
    typedef struct packed {
        logic [4:0] opcode;
        logic [2:0] func3;
        logic [6:0] func7;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } dec_bundle_t;

    // Immediate format implied by the major opcode (IMM_R means no immediate).
    function automatic imm_type_e imm_type_of(input logic [4:0] op);
        imm_type_e t;
        case (op)
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: t = IMM_I;
            OP_STORE:                            t = IMM_S;
            OP_BRANCH:                           t = IMM_B;
            OP_LUI, OP_AUIPC:                    t = IMM_U;
            OP_JAL:                              t = IMM_J;
            default:                             t = IMM_R;
        endcase
        return t;
    endfunction

    // Non-32-bit encodings and unsupported major opcodes are illegal.
    function automatic logic is_illegal(input logic [31:0] inst);
        logic known;
        case (inst[6:2])
            OP_LOAD, OP_MISC_MEM, OP_IMM, OP_AUIPC, OP_STORE, OP_OP,
            OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: known = 1'b1;
            default:                                       known = 1'b0;
        endcase
        return (inst[1:0] != 2'b11) || !known;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RISC-V immediate generator, sign-extended from inst[31] to XLEN.
module imm_gen
    import decode_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;
    logic        unused_len_bits;

    assign unused_len_bits = ^inst[1:0];

    // Assemble the 32-bit immediate for the format selected by the opcode.
    always_comb begin
        imm32 = '0;
        case (imm_type_of(inst[6:2]))
            IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm32 = {inst[31:12], 12'b0};
            IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_queue.sv
// Decode-at-enqueue instruction queue between fetch and issue.
// Optional feature: define DEC_ILLEGAL_CHK_EN to store and report an
// illegal-instruction flag per entry; otherwise dc_illegal is tied low.
module decode_queue
    import decode_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned PC_W  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       if_valid,
    output logic                       if_ready,
    input  logic [31:0]                if_inst,
    input  logic [PC_W-1:0]            if_pc,
    output logic                       dc_valid,
    input  logic                       dc_ready,
    output logic [4:0]                 dc_opcode,
    output logic [2:0]                 dc_func3,
    output logic [4:0]                 dc_func5,
    output logic [6:0]                 dc_func7,
    output logic [4:0]                 dc_rs1_index,
    output logic [4:0]                 dc_rs2_index,
    output logic [4:0]                 dc_rd_index,
    output logic [XLEN-1:0]            dc_imm,
    output logic [PC_W-1:0]            dc_pc,
    output logic                       dc_illegal,
    output logic [$clog2(DEPTH):0]     dc_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    dec_bundle_t     bundle_q [DEPTH];
    logic [XLEN-1:0] imm_q    [DEPTH];
    logic [PC_W-1:0] pc_q     [DEPTH];

    dec_bundle_t     bundle_in;
    logic [XLEN-1:0] imm_in;
    logic            full;
    logic            push;
    logic            pop;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst (if_inst),
        .imm  (imm_in)
    );

    // Field extraction for the incoming instruction.
    always_comb begin
        bundle_in        = '0;
        bundle_in.opcode = if_inst[6:2];
        bundle_in.func3  = if_inst[14:12];
        bundle_in.func7  = if_inst[31:25];
        bundle_in.rs1    = if_inst[19:15];
        bundle_in.rs2    = if_inst[24:20];
        bundle_in.rd     = if_inst[11:7];
    end

    assign full     = (count_q == CW'(DEPTH));
    assign if_ready = !full && !flush;
    assign dc_valid = (count_q != '0);
    assign push     = if_valid && if_ready;
    assign pop      = dc_valid && dc_ready && !flush;
    assign dc_count = count_q;

    // Pointer and occupancy next state; flush overrides push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written with the decoded bundle on push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bundle_q[i] <= '0;
                imm_q[i]    <= '0;
                pc_q[i]     <= '0;
            end
        end else if (push) begin
            bundle_q[wr_ptr_q] <= bundle_in;
            imm_q[wr_ptr_q]    <= imm_in;
            pc_q[wr_ptr_q]     <= if_pc;
        end
    end

`ifdef DEC_ILLEGAL_CHK_EN
    logic illegal_q [DEPTH];

    // Illegal flag computed at push and kept with its entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) illegal_q[i] <= 1'b0;
        end else if (push) begin
            illegal_q[wr_ptr_q] <= is_illegal(if_inst);
        end
    end

    assign dc_illegal = dc_valid && illegal_q[rd_ptr_q];
`else
    assign dc_illegal = 1'b0;
`endif

    // Head entry presentation, zeroed while the queue is empty.
    always_comb begin
        dc_opcode    = '0;
        dc_func3     = '0;
        dc_func5     = '0;
        dc_func7     = '0;
        dc_rs1_index = '0;
        dc_rs2_index = '0;
        dc_rd_index  = '0;
        dc_imm       = '0;
        dc_pc        = '0;
        if (dc_valid) begin
            dc_opcode    = bundle_q[rd_ptr_q].opcode;
            dc_func3     = bundle_q[rd_ptr_q].func3;
            dc_func5     = bundle_q[rd_ptr_q].func7[6:2];
            dc_func7     = bundle_q[rd_ptr_q].func7;
            dc_rs1_index = bundle_q[rd_ptr_q].rs1;
            dc_rs2_index = bundle_q[rd_ptr_q].rs2;
            dc_rd_index  = bundle_q[rd_ptr_q].rd;
            dc_imm       = imm_q[rd_ptr_q];
            dc_pc        = pc_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: default 32-bit instance plus a 64-bit
// immediate instance sharing the same stimulus.
module tb_decode_queue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        dc_ready;

    logic        if_ready;
    logic        dc_valid;
    logic [4:0]  dc_opcode;
    logic [2:0]  dc_func3;
    logic [4:0]  dc_func5;
    logic [6:0]  dc_func7;
    logic [4:0]  dc_rs1_index;
    logic [4:0]  dc_rs2_index;
    logic [4:0]  dc_rd_index;
    logic [31:0] dc_imm;
    logic [31:0] dc_pc;
    logic        dc_illegal;
    logic [1:0]  dc_count;

    logic        w_if_ready;
    logic        w_dc_valid;
    logic [4:0]  w_dc_opcode;
    logic [2:0]  w_dc_func3;
    logic [4:0]  w_dc_func5;
    logic [6:0]  w_dc_func7;
    logic [4:0]  w_dc_rs1_index;
    logic [4:0]  w_dc_rs2_index;
    logic [4:0]  w_dc_rd_index;
    logic [63:0] w_dc_imm;
    logic [31:0] w_dc_pc;
    logic        w_dc_illegal;
    logic [1:0]  w_dc_count;

    int n_vec = 0;
    int n_err = 0;

`ifdef DEC_ILLEGAL_CHK_EN
    localparam logic ILL_EXP = 1'b1;
`else
    localparam logic ILL_EXP = 1'b0;
`endif

    decode_queue #(.XLEN(32), .PC_W(32), .DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_inst      (if_inst),
        .if_pc        (if_pc),
        .dc_valid     (dc_valid),
        .dc_ready     (dc_ready),
        .dc_opcode    (dc_opcode),
        .dc_func3     (dc_func3),
        .dc_func5     (dc_func5),
        .dc_func7     (dc_func7),
        .dc_rs1_index (dc_rs1_index),
        .dc_rs2_index (dc_rs2_index),
        .dc_rd_index  (dc_rd_index),
        .dc_imm       (dc_imm),
        .dc_pc        (dc_pc),
        .dc_illegal   (dc_illegal),
        .dc_count     (dc_count)
    );

    decode_queue #(.XLEN(64), .PC_W(32), .DEPTH(2)) dut64 (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .if_valid     (if_valid),
        .if_ready     (w_if_ready),
        .if_inst      (if_inst),
        .if_pc        (if_pc),
        .dc_valid     (w_dc_valid),
        .dc_ready     (dc_ready),
        .dc_opcode    (w_dc_opcode),
        .dc_func3     (w_dc_func3),
        .dc_func5     (w_dc_func5),
        .dc_func7     (w_dc_func7),
        .dc_rs1_index (w_dc_rs1_index),
        .dc_rs2_index (w_dc_rs2_index),
        .dc_rd_index  (w_dc_rd_index),
        .dc_imm       (w_dc_imm),
        .dc_pc        (w_dc_pc),
        .dc_illegal   (w_dc_illegal),
        .dc_count     (w_dc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: inputs set before the call are sampled at the rising edge;
    // returns at the following falling edge where outputs are stable.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        if_valid = 1'b0;
        if_inst  = '0;
        if_pc    = '0;
        dc_ready = 1'b0;
        @(negedge clk);
        step();

        // Reset state
        chk("rst_valid", 64'(dc_valid), 64'd0);
        chk("rst_ready", 64'(if_ready), 64'd1);
        chk("rst_count", 64'(dc_count), 64'd0);
        chk("rst_imm",   64'(dc_imm),   64'd0);
        rst_n = 1'b1;

        // addi x1,x0,-1
        if_valid = 1'b1; if_inst = 32'hFFF00093; if_pc = 32'h0000_0100;
        step();
        if_valid = 1'b0;
        chk("addi_valid",  64'(dc_valid),     64'd1);
        chk("addi_count",  64'(dc_count),     64'd1);
        chk("addi_op",     64'(dc_opcode),    64'h04);
        chk("addi_rd",     64'(dc_rd_index),  64'd1);
        chk("addi_rs1",    64'(dc_rs1_index), 64'd0);
        chk("addi_rs2",    64'(dc_rs2_index), 64'h1F);
        chk("addi_f3",     64'(dc_func3),     64'd0);
        chk("addi_f7",     64'(dc_func7),     64'h7F);
        chk("addi_f5",     64'(dc_func5),     64'h1F);
        chk("addi_imm",    64'(dc_imm),       64'hFFFF_FFFF);
        chk("addi_pc",     64'(dc_pc),        64'h100);
        chk("addi_ill",    64'(dc_illegal),   64'd0);
        chk("addi_imm64",  w_dc_imm,          64'hFFFF_FFFF_FFFF_FFFF);
        dc_ready = 1'b1;
        step();
        chk("pop_valid",   64'(dc_valid),     64'd0);
        chk("pop_imm0",    64'(dc_imm),       64'd0);
        chk("pop_op0",     64'(dc_opcode),    64'd0);

        // Back-to-back sw, beq, lui with consumer always ready
        if_valid = 1'b1; if_inst = 32'h0020A423; if_pc = 32'h200;
        step();
        chk("sw_imm",      64'(dc_imm),       64'd8);
        chk("sw_op",       64'(dc_opcode),    64'h08);
        if_inst = 32'hFE000EE3; if_pc = 32'h204;
        step();
        chk("beq_imm",     64'(dc_imm),       64'hFFFF_FFFC);
        chk("beq_imm64",   w_dc_imm,          64'hFFFF_FFFF_FFFF_FFFC);
        chk("beq_count",   64'(dc_count),     64'd1);
        chk("beq_pc",      64'(dc_pc),        64'h204);
        if_inst = 32'h123452B7; if_pc = 32'h208;
        step();
        if_valid = 1'b0;
        chk("lui_imm",     64'(dc_imm),       64'h1234_5000);
        chk("lui_imm64",   w_dc_imm,          64'h0000_0000_1234_5000);
        chk("lui_rd",      64'(dc_rd_index),  64'd5);
        chk("lui_op",      64'(dc_opcode),    64'h0D);
        step();
        chk("drain_valid", 64'(dc_valid),     64'd0);

        // Fill with consumer stalled, then single pop
        dc_ready = 1'b0;
        if_valid = 1'b1; if_inst = 32'h00100093; if_pc = 32'h300;
        step();
        if_inst = 32'h00200113; if_pc = 32'h304;
        step();
        chk("full_ready",  64'(if_ready),     64'd0);
        chk("full_count",  64'(dc_count),     64'd2);
        chk("full_head",   64'(dc_imm),       64'd1);
        if_inst = 32'h00300193; if_pc = 32'h308;
        step();
        chk("full_hold",   64'(dc_count),     64'd2);
        dc_ready = 1'b1;
        step();
        dc_ready = 1'b0;
        chk("pop1_count",  64'(dc_count),     64'd1);
        chk("pop1_ready",  64'(if_ready),     64'd1);
        chk("pop1_head",   64'(dc_imm),       64'd2);
        step();
        if_valid = 1'b0;
        chk("refill_cnt",  64'(dc_count),     64'd2);
        dc_ready = 1'b1;
        step();
        chk("order_2nd",   64'(dc_imm),       64'd3);
        chk("order_pc",    64'(dc_pc),        64'h308);
        step();
        chk("order_empty", 64'(dc_valid),     64'd0);

        // Flush with push and pop in the same cycle
        dc_ready = 1'b0;
        if_valid = 1'b1; if_inst = 32'h00400213;
        step();
        if_inst = 32'h00500293;
        step();
        chk("pre_fl_cnt",  64'(dc_count),     64'd2);
        flush = 1'b1; dc_ready = 1'b1; if_inst = 32'h00600313;
        #1;
        chk("fl_ready",    64'(if_ready),     64'd0);
        step();
        flush = 1'b0;
        chk("fl_count",    64'(dc_count),     64'd0);
        chk("fl_valid",    64'(dc_valid),     64'd0);
        dc_ready = 1'b0; if_inst = 32'h00700393;
        step();
        if_valid = 1'b0;
        chk("post_fl_cnt", 64'(dc_count),     64'd1);
        chk("post_fl_imm", 64'(dc_imm),       64'd7);
        dc_ready = 1'b1;
        step();
        chk("post_fl_emp", 64'(dc_valid),     64'd0);

        // Illegal encodings
        dc_ready = 1'b0;
        if_valid = 1'b1; if_inst = 32'h00000000;
        step();
        if_inst = 32'h0000007F;
        step();
        if_valid = 1'b0;
        chk("ill0_flag",   64'(dc_illegal),   64'(ILL_EXP));
        chk("ill0_imm",    64'(dc_imm),       64'd0);
        dc_ready = 1'b1;
        step();
        dc_ready = 1'b0;
        chk("ill7f_flag",  64'(dc_illegal),   64'(ILL_EXP));
        chk("ill7f_op",    64'(dc_opcode),    64'h1F);
        chk("ill7f_imm",   64'(dc_imm),       64'd0);

        // Reset while full
        if_valid = 1'b1; if_inst = 32'hFFF00093;
        step();
        chk("prer_count",  64'(dc_count),     64'd2);
        if_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rstf_valid",  64'(dc_valid),     64'd0);
        chk("rstf_ready",  64'(if_ready),     64'd1);
        chk("rstf_imm",    64'(dc_imm),       64'd0);
        chk("rstf_count",  64'(dc_count),     64'd0);
        step();
        chk("rstf_stay",   64'(dc_valid),     64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
